// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: runs one FIR multiply-accumulate pass per queue read window,
// steps the coefficient ROM address in lock-step, then rounds, saturates and emits
// one filtered sample. Malformed windows raise a sticky error instead of an output.
module fir_tap_sequencer #(
    parameter int unsigned TAPS  = 1021,
    parameter int unsigned SHIFT = 15,
    parameter int unsigned ACC_W = 42
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sequencing,
    input  logic signed [15:0] smpl_in,
    input  logic signed [15:0] coeff_in,
    input  logic               clr_err,
    output logic [9:0]         coeff_addr,
    output logic signed [15:0] filt_out,
    output logic               filt_vld,
    output logic               seq_err,
    output logic               busy
);

    localparam int unsigned OUT_W  = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = $clog2(TAPS + 1);
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(2 ** (SHIFT - 1));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        SKIP  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_d;
    logic signed [PROD_W-1:0]  r_prod;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_d;
    logic [ADDR_W-1:0]         r_coeff_addr;
    logic [ADDR_W-1:0]         w_addr_d;
    logic signed [OUT_W-1:0]   r_filt_out;
    logic                      r_filt_vld;
    logic                      r_seq_err;
    logic                      r_busy;
    logic                      r_seq_q;
    logic                      w_prod_ld;
    logic                      w_acc_clr;
    logic                      w_acc_add;
    logic                      w_err_set;
    logic                      w_out_ld;
    logic signed [ACC_W-1:0]   w_rnd;
    logic signed [OUT_W-1:0]   w_sat;

    // Next-state and datapath control; a window is only accepted on a fresh rise.
    always_comb begin
        w_state_d = r_state;
        w_prod_ld = 1'b0;
        w_acc_clr = 1'b0;
        w_acc_add = 1'b0;
        w_cnt_d   = r_cnt;
        w_addr_d  = r_coeff_addr;
        w_err_set = 1'b0;
        w_out_ld  = 1'b0;
        case (r_state)
            IDLE: begin
                w_addr_d = '0;
                if (sequencing) begin
                    if (r_seq_q) begin
                        // Window already in progress (overrun or high at reset release).
                        w_state_d = SKIP;
                    end else begin
                        w_prod_ld = 1'b1;
                        w_acc_clr = 1'b1;
                        w_cnt_d   = CNT_W'(1);
                        w_addr_d  = ADDR_W'(1);
                        w_state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (sequencing) begin
                    w_prod_ld = 1'b1;
                    w_acc_add = 1'b1;
                    w_cnt_d   = r_cnt + CNT_W'(1);
                    w_addr_d  = r_coeff_addr + ADDR_W'(1);
                    if (r_cnt == CNT_W'(TAPS - 1)) begin
                        w_state_d = DRAIN;
                    end
                end else begin
                    // Short window.
                    w_err_set = 1'b1;
                    w_addr_d  = '0;
                    w_state_d = IDLE;
                end
            end
            DRAIN: begin
                w_acc_add = 1'b1;
                w_addr_d  = '0;
                if (sequencing) begin
                    // Long window: still streaming after the last tap.
                    w_err_set = 1'b1;
                    w_state_d = SKIP;
                end else begin
                    w_state_d = OUT;
                end
            end
            OUT: begin
                w_out_ld  = 1'b1;
                w_state_d = IDLE;
                if (sequencing) begin
                    w_err_set = 1'b1;
                end
            end
            SKIP: begin
                w_addr_d = '0;
                if (!sequencing) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_addr_d  = '0;
                w_state_d = IDLE;
            end
        endcase
    end

    // Round half up, arithmetic shift, then saturate to the 16-bit output range.
    always_comb begin
        w_rnd = (r_acc + RND_BIAS) >>> SHIFT;
        if ((w_rnd[ACC_W-1:OUT_W-1] == '0) || (w_rnd[ACC_W-1:OUT_W-1] == '1)) begin
            w_sat = w_rnd[OUT_W-1:0];
        end else if (w_rnd[ACC_W-1]) begin
            w_sat = 16'sh8000;
        end else begin
            w_sat = 16'sh7FFF;
        end
    end

    // State register and control-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_coeff_addr <= '0;
            r_busy       <= 1'b0;
            r_seq_q      <= 1'b1;
            r_seq_err    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_coeff_addr <= w_addr_d;
            r_busy       <= (w_state_d != IDLE);
            r_seq_q      <= sequencing;
            if (w_err_set) begin
                r_seq_err <= 1'b1;
            end else if (clr_err) begin
                r_seq_err <= 1'b0;
            end
        end
    end

    // Multiply-accumulate pipeline and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod     <= '0;
            r_acc      <= '0;
            r_filt_out <= '0;
            r_filt_vld <= 1'b0;
        end else begin
            if (w_prod_ld) begin
                r_prod <= PROD_W'(smpl_in) * PROD_W'(coeff_in);
            end
            if (w_acc_clr) begin
                r_acc <= '0;
            end else if (w_acc_add) begin
                r_acc <= r_acc + {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
            end
            if (w_out_ld) begin
                r_filt_out <= w_sat;
            end
            r_filt_vld <= w_out_ld;
        end
    end

    assign coeff_addr = r_coeff_addr;
    assign filt_out   = r_filt_out;
    assign filt_vld   = r_filt_vld;
    assign seq_err    = r_seq_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized self-checking bench for fir_tap_sequencer with a window-level reference model.
module tb_fir_tap_sequencer;

    localparam int unsigned TAPS  = 1021;
    localparam int unsigned SHIFT = 15;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sequencing;
    logic               clr_err;
    logic signed [15:0] smpl_in;
    logic signed [15:0] coeff_in;
    logic signed [15:0] filt_out;
    logic [9:0]         coeff_addr;
    logic               filt_vld;
    logic               seq_err;
    logic               busy;

    logic signed [15:0] rom [0:1023];
    logic signed [15:0] smp [0:1099];
    logic [15:0]        fo_u;
    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 n_vld    = 0;
    int                 base;
    logic               exp_err;
    logic [15:0]        exp1;

    fir_tap_sequencer #(.TAPS(TAPS), .SHIFT(SHIFT), .ACC_W(42)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coeff_in   (coeff_in),
        .clr_err    (clr_err),
        .coeff_addr (coeff_addr),
        .filt_out   (filt_out),
        .filt_vld   (filt_vld),
        .seq_err    (seq_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ROM answers for the address the DUT registered on the previous edge.
    assign coeff_in = rom[coeff_addr];
    assign fo_u     = filt_out;

    always @(negedge clk) if (filt_vld) n_vld <= n_vld + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference: full dot product, round half up, saturate.
    function automatic logic [15:0] ref_filt(input int len);
        longint acc = 0;
        for (int k = 0; k < len; k++) acc += longint'(smp[k]) * longint'(rom[k]);
        acc = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    task automatic fill_const(input logic [15:0] cv, input logic [15:0] sv);
        for (int k = 0; k < 1024; k++) rom[k] = cv;
        for (int k = 0; k < 1100; k++) smp[k] = sv;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 1024; k++) rom[k] = 16'(int'($urandom_range(0, 2047)) - 1024);
        for (int k = 0; k < 1100; k++) smp[k] = 16'($urandom);
    endtask

    // Drive len samples; leaves sequencing high after the last one.
    task automatic send(input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k <= int'(TAPS)) check("addr", 64'(coeff_addr), 64'(k));
            if (k == 0) check("busy_c0", 64'(busy), 64'd0);
            if (k == 1) check("busy_c1", 64'(busy), 64'd1);
            sequencing = 1'b1;
            smpl_in    = smp[k];
        end
    endtask

    // After a full window: result exactly at L+3 as a single pulse.
    task automatic finish_valid(input logic [15:0] expv);
        @(negedge clk);
        check("addr_end", 64'(coeff_addr), 64'(TAPS));
        sequencing = 1'b0;
        @(negedge clk);
        check("vld_early", 64'(filt_vld), 64'd0);
        check("addr_ret", 64'(coeff_addr), 64'd0);
        @(negedge clk);
        check("vld", 64'(filt_vld), 64'd1);
        check("out", 64'(fo_u), 64'(expv));
        check("busy_end", 64'(busy), 64'd0);
        check("err", 64'(seq_err), 64'(exp_err));
        @(negedge clk);
        check("vld_pulse", 64'(filt_vld), 64'd0);
    endtask

    task automatic finish_error();
        @(negedge clk);
        sequencing = 1'b0;
        repeat (6) @(negedge clk);
        check("no_vld", 64'(n_vld), 64'(base));
        check("err_set", 64'(seq_err), 64'd1);
        check("addr_idle", 64'(coeff_addr), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        @(negedge clk);
        check("err_clr", 64'(seq_err), 64'd0);
        clr_err = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sequencing = 1'b0; smpl_in = '0; clr_err = 1'b0; exp_err = 1'b0;
        fill_const(16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check("rst_addr", 64'(coeff_addr), 64'd0);
        check("rst_out", 64'(fo_u), 64'd0);
        check("rst_vld", 64'(filt_vld), 64'd0);
        check("rst_err", 64'(seq_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // DC window
        fill_const(16'h4000, 16'h0002);
        send(TAPS); finish_valid(ref_filt(TAPS));
        check("dc_val", 64'(fo_u), 64'h03FD);

        // Saturation both ways
        fill_const(16'h7FFF, 16'h7FFF);
        send(TAPS); finish_valid(16'h7FFF);
        fill_const(16'h7FFF, 16'h8000);
        send(TAPS); finish_valid(16'h8000);

        // Impulse at tap 37 with coeff[k] = k
        fill_const(16'h0000, 16'h0000);
        for (int k = 0; k < 1024; k++) rom[k] = 16'(k);
        smp[37] = 16'h7FFF;
        send(TAPS); finish_valid(ref_filt(TAPS));
        check("imp_val", 64'(fo_u), 64'd37);

        // Random windows with random gaps
        for (int w = 0; w < 4; w++) begin
            fill_random();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(TAPS); finish_valid(ref_filt(TAPS));
        end

        // Short window
        base = n_vld;
        fill_random();
        send(500); finish_error();
        clear_err();

        // Error set and clear in the same cycle: set wins
        base = n_vld;
        clr_err = 1'b1;
        send(10);
        @(negedge clk); sequencing = 1'b0;
        @(negedge clk);
        check("set_dominates", 64'(seq_err), 64'd1);
        clr_err = 1'b0;
        @(negedge clk);
        check("err_sticky", 64'(seq_err), 64'd1);
        clear_err();

        // Long window, then a clean window
        base = n_vld;
        fill_random();
        send(1025); finish_error();
        clear_err();
        fill_random();
        send(TAPS); finish_valid(ref_filt(TAPS));

        // Overrun: second window rises one idle cycle after L
        base = n_vld;
        fill_random();
        send(TAPS);
        exp1 = ref_filt(TAPS);
        @(negedge clk);
        check("ovr_addr", 64'(coeff_addr), 64'(TAPS));
        sequencing = 1'b0;
        for (int k = 0; k < int'(TAPS); k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("ovr_vld", 64'(filt_vld), 64'd1);
                check("ovr_out", 64'(fo_u), 64'(exp1));
                check("ovr_err", 64'(seq_err), 64'd1);
            end
            sequencing = 1'b1;
            smpl_in    = 16'($urandom);
        end
        @(negedge clk); sequencing = 1'b0;
        repeat (6) @(negedge clk);
        check("ovr_count", 64'(n_vld), 64'(base + 1));
        check("ovr_busy", 64'(busy), 64'd0);
        clear_err();

        // Reset mid-run, released with sequencing still high
        fill_const(16'h4000, 16'h0002);
        base = n_vld;
        send(400);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_addr", 64'(coeff_addr), 64'd0);
        check("mrst_out", 64'(fo_u), 64'd0);
        check("mrst_vld", 64'(filt_vld), 64'd0);
        check("mrst_err", 64'(seq_err), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("skip_busy", 64'(busy), 64'd1);
        check("skip_addr", 64'(coeff_addr), 64'd0);
        sequencing = 1'b0;
        repeat (5) @(negedge clk);
        check("skip_novld", 64'(n_vld), 64'(base));
        check("skip_noerr", 64'(seq_err), 64'd0);
        send(TAPS); finish_valid(16'h03FD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
